// File: rtl/ram_responder.sv
// Memory-side responder for the mobo four-phase RAM handshake, backed by a word array.
// Optional address bounds checking (err bit, dropped writes, 0xDEADBEEF reads) with `define RAM_BOUNDS_EN.
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module ram_responder #(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ctrl_in,
   output logic [31:0] ctrl_out,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);

   localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [31:0]      OOB_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              wr_q, wr_d;
   logic              oob_q, oob_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem_q [DEPTH];
   logic              mem_we;

   logic rd_req, wr_req, addr_oob;
   logic unused_bits;

   assign rd_req      = ctrl_in[`RAM_READ_PIN];
   assign wr_req      = ctrl_in[`RAM_WRITE_PIN];
   assign unused_bits = ^{ctrl_in, addr[31:ADDR_W]};

`ifdef RAM_BOUNDS_EN
   assign addr_oob = |addr[31:ADDR_W];
`else
   assign addr_oob = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      err_d   = err_q;
      wr_d    = wr_q;
      oob_d   = oob_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((rd_req || wr_req) && !ack_q) begin
               state_d = S_BUSY;
               cnt_d   = CNT_INIT;
               wr_d    = wr_req;
               idx_d   = addr[ADDR_W-1:0];
               oob_d   = addr_oob;
               wdata_d = data_in;
            end
         end
         S_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               err_d   = oob_q;
               if (wr_q) mem_we  = !oob_q;
               else      rdata_d = oob_q ? OOB_DATA : mem_q[idx_q];
            end
         end
         S_ACK: begin
            if (!rd_req && !wr_req) begin
               state_d = S_IDLE;
               ack_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         oob_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         oob_q   <= oob_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // NOTE: the array has no reset; contents survive rst and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[idx_q] <= wdata_q;
   end

   always_comb begin
      ctrl_out             = '0;
      ctrl_out[`RAM_ACK]   = ack_q;
      ctrl_out[31]         = err_q;
   end

   assign data_out = rdata_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: transaction-level timeline model plus per-cycle compare.
// Build with +define+RAM_BOUNDS_EN to exercise the bounds-checking variant.
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module tb_ram_responder;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;
   localparam int LAT    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl_in, addr, data_in;
   logic [31:0] ctrl_out, data_out;

   int          n_vec = 0;
   int          n_err = 0;
   bit          cmp_en = 1'b0;
   logic [31:0] exp_ctrl, exp_data;
   logic [31:0] mem_m [DEPTH];

   ram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_in (ctrl_in),
      .ctrl_out(ctrl_out),
      .addr    (addr),
      .data_in (data_in),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_ctrl(input bit ack, input bit err);
      logic [31:0] c;
      c = '0;
      c[`RAM_ACK] = ack;
      c[31] = err;
      return c;
   endfunction

   function automatic bit is_oob(input logic [31:0] a);
`ifdef RAM_BOUNDS_EN
      return a >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ctrl_out", ctrl_out, exp_ctrl);
         check("data_out", data_out, exp_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit rd, input bit wr);
      ctrl_in = '0;
      ctrl_in[`RAM_READ_PIN]  = rd;
      ctrl_in[`RAM_WRITE_PIN] = wr;
   endtask

   // One full four-phase transaction; the model state changes at the edge ack must rise on.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input bit scramble);
      int unsigned idx;
      set_req(rd, wr);
      addr    = a;
      data_in = d;
      step();
      for (int i = 1; i <= LAT; i++) begin
         if (scramble) begin
            set_req(i % 2 == 1, i % 2 == 0);
            addr    = $urandom;
            data_in = $urandom;
         end
         step();
      end
      idx = a % DEPTH;
      if (wr) begin
         if (!is_oob(a)) mem_m[idx] = d;
      end else begin
         exp_data = is_oob(a) ? 32'hDEAD_BEEF : mem_m[idx];
      end
      exp_ctrl = mk_ctrl(1'b1, is_oob(a));
      for (int i = 0; i < hold; i++) begin
         if (scramble) begin
            set_req(i % 2 == 0, i % 2 == 1);
            addr    = $urandom;
            data_in = $urandom;
         end
         step();
      end
      ctrl_in = '0;
      step();
      exp_ctrl = mk_ctrl(1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      ctrl_in  = '0;
      addr     = '0;
      data_in  = '0;
      exp_ctrl = '0;
      exp_data = '0;
      cmp_en   = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_ctrl", ctrl_out, 32'h0);
      check("reset_data", data_out, 32'h0);
      step();

      // Basic write then read-back; data_out must hold across idle cycles and writes.
      txn(1'b0, 1'b1, 32'd5, 32'h0000_1234, 0, 1'b0);
      txn(1'b1, 1'b0, 32'd5, 32'h0, 0, 1'b0);
      check("t2_read5", data_out, 32'h0000_1234);
      repeat (3) step();
      check("t2_hold", data_out, 32'h0000_1234);

      // rd and wr together is a write.
      txn(1'b1, 1'b1, 32'd7, 32'h0000_00AA, 0, 1'b0);
      check("t3_wr_keeps_data", data_out, 32'h0000_1234);
      txn(1'b1, 1'b0, 32'd7, 32'h0, 0, 1'b0);
      check("t3_read7", data_out, 32'h0000_00AA);

      // Long ack hold and request churn during BUSY/ACK.
      txn(1'b0, 1'b1, 32'd20, 32'h0000_BEEF, 5, 1'b1);
      txn(1'b1, 1'b0, 32'd20, 32'h0, 5, 1'b1);
      check("t4_read20", data_out, 32'h0000_BEEF);
      txn(1'b1, 1'b0, 32'd5, 32'h0, 5, 1'b0);
      check("t4_reread5", data_out, 32'h0000_1234);

      // Reset during BUSY aborts the write.
      txn(1'b0, 1'b1, 32'd9, 32'h0000_0077, 0, 1'b0);
      set_req(1'b0, 1'b1);
      addr    = 32'd9;
      data_in = 32'h0000_0055;
      step();
      #2;
      rst      = 1'b1;
      exp_ctrl = '0;
      exp_data = '0;
      #1;
      check("t5_rst_ctrl", ctrl_out, 32'h0);
      check("t5_rst_data", data_out, 32'h0);
      ctrl_in = '0;
      step();
      step();
      rst = 1'b0;
      step();
      txn(1'b1, 1'b0, 32'd9, 32'h0, 0, 1'b0);
      check("t5_read9", data_out, 32'h0000_0077);

      // Address above DEPTH.
      txn(1'b0, 1'b1, 32'd3, 32'h0000_0033, 0, 1'b0);
      txn(1'b0, 1'b1, DEPTH + 3, 32'h0000_CAFE, 0, 1'b0);
      txn(1'b1, 1'b0, 32'd3, 32'h0, 0, 1'b0);
`ifdef RAM_BOUNDS_EN
      check("t6_word3_untouched", data_out, 32'h0000_0033);
`else
      check("t6_word3_wrapped", data_out, 32'h0000_CAFE);
`endif
      set_req(1'b1, 1'b0);
      addr = DEPTH + 3;
      repeat (LAT + 1) step();
`ifdef RAM_BOUNDS_EN
      exp_ctrl = mk_ctrl(1'b1, 1'b1);
      exp_data = 32'hDEAD_BEEF;
      check("t6_oob_err", ctrl_out, mk_ctrl(1'b1, 1'b1));
      check("t6_oob_data", data_out, 32'hDEAD_BEEF);
`else
      exp_ctrl = mk_ctrl(1'b1, 1'b0);
      exp_data = 32'h0000_CAFE;
      check("t6_wrap_ack", ctrl_out, mk_ctrl(1'b1, 1'b0));
      check("t6_wrap_data", data_out, 32'h0000_CAFE);
`endif
      ctrl_in = '0;
      step();
      exp_ctrl = '0;
      check("t6_ack_fall", ctrl_out, 32'h0);
      repeat (2) step();

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
